gc_tlp_wr: RTL and testbench

- Downstream consumer of the gc update mixer output (gc_addr / gc_updt / gc_updt_ack).
- For each accepted update request it builds one PCIe posted Memory Write TLP carrying a 64-bit gc value to host address gc_addr.
- It drives that TLP onto the shared 64-bit TRN TX interface after winning TX arbitration.
- gc_updt_ack is returned only once the TLP's last beat has been accepted by the core, so updates reach the host strictly in mixer order.

---
 rtl/gc_tlp_wr.sv | 191 +++++++++++++++++++
 tb/tb_gc_tlp_wr.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_tlp_wr.sv
// Posted MWr TLP writer for gc updates: turns each mixer request into one
// 3DW/4DW Memory Write on the 64-bit TRN TX bus and acks it once fully sent.
module gc_tlp_wr #(
  parameter bit FORCE_4DW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] gc_addr,
  input  logic        gc_updt,
  output logic        gc_updt_ack,
  input  logic [63:0] gc_data,
  input  logic [15:0] cfg_completer_id,
  input  logic        trn_lnk_up_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tbuf_av,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic        tx_done,
  output logic [31:0] gc_wr_cnt
);

  typedef enum logic [2:0] {IDLE, ARB, BEAT0, BEAT1, BEAT2, HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [15:0] id_q, id_d;
  logic        is4dw_q, is4dw_d;
  logic        tx_req_q, tx_req_d;
  logic        tx_done_q, tx_done_d;
  logic        ack_q, ack_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic [63:0] td_q, td_d;
  logic [7:0]  trem_n_q, trem_n_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] h0, h1, d0, d1;
  logic [63:0] beat0, beat1, beat2;
  logic        link_up, accept;

  assign link_up = ~trn_lnk_up_n;
  assign accept  = ~src_rdy_n_q & ~trn_tdst_rdy_n;

  // Header/payload words come only from latched values so the TLP in flight
  // is immune to later changes on gc_addr/gc_data.
  assign h0 = {1'b0, (is4dw_q ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'b0000,
               1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
  assign h1 = {id_q, 8'h00, 4'hF, 4'hF};
  assign d0 = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
  assign d1 = {data_q[39:32], data_q[47:40], data_q[55:48], data_q[63:56]};

  assign beat0 = {h0, h1};
  assign beat1 = is4dw_q ? {addr_q[63:32], addr_q[31:2], 2'b00}
                         : {addr_q[31:2], 2'b00, d0};
  assign beat2 = is4dw_q ? {d0, d1} : {d1, 32'h0000_0000};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    id_d        = id_q;
    is4dw_d     = is4dw_q;
    tx_req_d    = tx_req_q;
    tx_done_d   = 1'b0;
    ack_d       = 1'b0;
    sof_n_d     = sof_n_q;
    eof_n_d     = eof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    td_d        = td_q;
    trem_n_d    = trem_n_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (gc_updt && link_up) begin
          addr_d   = gc_addr;
          data_d   = gc_data;
          id_d     = cfg_completer_id;
          is4dw_d  = FORCE_4DW | (|gc_addr[63:32]);
          tx_req_d = 1'b1;
          state_d  = ARB;
        end
      end
      ARB: begin
        if (!link_up) begin
          tx_req_d = 1'b0;
          state_d  = IDLE;
        end else if (tx_grant && trn_tbuf_av) begin
          td_d        = beat0;
          trem_n_d    = 8'h00;
          sof_n_d     = 1'b0;
          src_rdy_n_d = 1'b0;
          state_d     = BEAT0;
        end
      end
      BEAT0, BEAT1, BEAT2: begin
        // Link loss abandons the TLP; gc_updt stays pending and is retried.
        if (!link_up) begin
          td_d        = '0;
          trem_n_d    = 8'hFF;
          sof_n_d     = 1'b1;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
          tx_req_d    = 1'b0;
          tx_done_d   = 1'b1;
          state_d     = IDLE;
        end else if (accept) begin
          case (state_q)
            BEAT0: begin
              td_d    = beat1;
              sof_n_d = 1'b1;
              state_d = BEAT1;
            end
            BEAT1: begin
              td_d     = beat2;
              eof_n_d  = 1'b0;
              trem_n_d = is4dw_q ? 8'h00 : 8'h0F;
              state_d  = BEAT2;
            end
            default: begin
              td_d        = '0;
              trem_n_d    = 8'hFF;
              eof_n_d     = 1'b1;
              src_rdy_n_d = 1'b1;
              tx_req_d    = 1'b0;
              tx_done_d   = 1'b1;
              ack_d       = 1'b1;
              cnt_d       = cnt_q + 32'd1;
              state_d     = HOLD;
            end
          endcase
        end
      end
      // The mixer drops gc_updt one cycle after ack; skip that cycle.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      is4dw_q     <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_done_q   <= 1'b0;
      ack_q       <= 1'b0;
      sof_n_q     <= 1'b1;
      eof_n_q     <= 1'b1;
      src_rdy_n_q <= 1'b1;
      td_q        <= '0;
      trem_n_q    <= 8'hFF;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      is4dw_q     <= is4dw_d;
      tx_req_q    <= tx_req_d;
      tx_done_q   <= tx_done_d;
      ack_q       <= ack_d;
      sof_n_q     <= sof_n_d;
      eof_n_q     <= eof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
      td_q        <= td_d;
      trem_n_q    <= trem_n_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gc_updt_ack    = ack_q;
  assign tx_req         = tx_req_q;
  assign tx_done        = tx_done_q;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = src_rdy_n_q;
  assign trn_td         = td_q;
  assign trn_trem_n     = trem_n_q;
  assign gc_wr_cnt      = cnt_q;

endmodule

// File: tb/tb_gc_tlp_wr.sv
// Scoreboard bench for gc_tlp_wr: expected TRN beats are queued at stimulus
// time and checked by a monitor as the core accepts them.
module tb_gc_tlp_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] gc_addr;
  logic        gc_updt;
  logic        gc_updt_ack;
  logic [63:0] gc_data;
  logic [15:0] cfg_completer_id;
  logic        trn_lnk_up_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tbuf_av;
  logic        tx_req;
  logic        tx_grant;
  logic        tx_done;
  logic [31:0] gc_wr_cnt;

  always #5 clk = ~clk;

  gc_tlp_wr #(.FORCE_4DW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .gc_addr(gc_addr), .gc_updt(gc_updt), .gc_updt_ack(gc_updt_ack),
    .gc_data(gc_data), .cfg_completer_id(cfg_completer_id),
    .trn_lnk_up_n(trn_lnk_up_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_tbuf_av(trn_tbuf_av), .tx_req(tx_req), .tx_grant(tx_grant),
    .tx_done(tx_done), .gc_wr_cnt(gc_wr_cnt)
  );

  typedef struct packed {
    logic [63:0] td;
    logic        sof;
    logic        eof;
    logic [7:0]  trem;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_count = 0;
  bit    stall_en = 1'b0;
  int    stall_cnt = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic push_raw(input logic [63:0] td, input logic sof, input logic eof, input logic [7:0] trem);
    beat_t b;
    b.td = td; b.sof = sof; b.eof = eof; b.trem = trem;
    exp_q.push_back(b);
  endtask

  // Reference TLP builder: queues the first nbeats beats of one write.
  task automatic push_tlp(input logic [63:0] a, input logic [63:0] d, input int nbeats);
    logic        is4;
    logic [31:0] hw0, hw1, p0, p1;
    logic [63:0] w [3];
    is4 = (a[63:32] != 32'h0);
    hw0 = {1'b0, (is4 ? 2'b11 : 2'b10), 19'd0, 10'd2};
    hw1 = {cfg_completer_id, 16'h00FF};
    p0  = bswap(d[31:0]);
    p1  = bswap(d[63:32]);
    w[0] = {hw0, hw1};
    w[1] = is4 ? {a[63:2], 2'b00} : {a[31:2], 2'b00, p0};
    w[2] = is4 ? {p0, p1} : {p1, 32'h0};
    for (int k = 0; k < nbeats; k++)
      push_raw(w[k], k == 0, k == 2, (k == 2) ? (is4 ? 8'h00 : 8'h0F) : 8'h00);
  endtask

  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] d);
    gc_addr = a;
    gc_data = d;
    gc_updt = 1'b1;
  endtask

  // mode 1 scrambles gc_addr/gc_data mid-TLP, mode 2 drops tx_grant mid-TLP.
  task automatic wait_ack(input int mode, output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++; #1;
      if (lat == 2 && mode == 1) begin
        gc_addr = 64'hFFFF_0000_DEAD_BEEC;
        gc_data = ~gc_data;
      end
      if (lat == 2 && mode == 2) tx_grant = 1'b0;
      if (gc_updt_ack) break;
    end
    if (!gc_updt_ack) begin
      vectors++; miscompares++;
      $display("[TB] FAIL ack_timeout: got no ack in %0d cycles, required ack", lat);
    end
    tx_grant = 1'b1;
    @(posedge clk); #1;
    check_output("hold_no_restart", tx_req, 0);
    gc_updt = 1'b0;
  endtask

  // Core-side backpressure: holds each beat off for three cycles when enabled.
  initial begin
    trn_tdst_rdy_n = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_en && !trn_tsrc_rdy_n) begin
        if (stall_cnt < 3) begin
          trn_tdst_rdy_n = 1'b1; stall_cnt++;
        end else begin
          trn_tdst_rdy_n = 1'b0; stall_cnt = 0;
        end
      end else begin
        trn_tdst_rdy_n = 1'b0; stall_cnt = 0;
      end
    end
  end

  logic        prev_pending = 1'b0;
  logic [63:0] prev_td;
  logic        prev_sof, prev_eof;

  initial begin : monitor
    beat_t b;
    logic  acc;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        acc = !trn_tsrc_rdy_n && !trn_tdst_rdy_n && !trn_lnk_up_n;
        if (prev_pending && !trn_tsrc_rdy_n && !trn_lnk_up_n) begin
          check_output("stall_td_stable", trn_td, prev_td);
          check_output("stall_sof_stable", trn_tsof_n, prev_sof);
          check_output("stall_eof_stable", trn_teof_n, prev_eof);
        end
        prev_pending = !trn_tsrc_rdy_n && !acc && !trn_lnk_up_n;
        prev_td = trn_td; prev_sof = trn_tsof_n; prev_eof = trn_teof_n;
        if (acc) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL unexpected_beat: got td 0x%0h, required no beat", trn_td);
          end else begin
            b = exp_q.pop_front();
            check_output("beat_td", trn_td, b.td);
            check_output("beat_sof_n", trn_tsof_n, !b.sof);
            check_output("beat_eof_n", trn_teof_n, !b.eof);
            if (b.eof) check_output("beat_trem_n", trn_trem_n, b.trem);
          end
        end
        if (gc_updt_ack) begin
          exp_count++;
          check_output("gc_wr_cnt", gc_wr_cnt, exp_count);
          check_output("ack_all_beats_sent", exp_q.size(), 0);
          check_output("ack_tx_done", tx_done, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int lat;
    rst_n = 1'b0; gc_updt = 1'b0; gc_addr = '0; gc_data = '0;
    cfg_completer_id = 16'h0100; trn_lnk_up_n = 1'b0;
    trn_tbuf_av = 1'b1; tx_grant = 1'b1;
    #12;
    check_output("rst_ack", gc_updt_ack, 0);
    check_output("rst_tx_req", tx_req, 0);
    check_output("rst_tx_done", tx_done, 0);
    check_output("rst_sof_n", trn_tsof_n, 1);
    check_output("rst_eof_n", trn_teof_n, 1);
    check_output("rst_src_rdy_n", trn_tsrc_rdy_n, 1);
    check_output("rst_td", trn_td, 0);
    check_output("rst_trem_n", trn_trem_n, 8'hFF);
    check_output("rst_cnt", gc_wr_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] 3DW path");
    push_raw(64'h40000002_010000FF, 1'b1, 1'b0, 8'h00);
    push_raw(64'h12345678_77665544, 1'b0, 1'b0, 8'h00);
    push_raw(64'h33221100_00000000, 1'b0, 1'b1, 8'h0F);
    apply_stimulus(64'h0000_0000_1234_5678, 64'h0011_2233_4455_6677);
    wait_ack(1, lat);
    check_output("latency_3dw", lat, 5);

    $display("[TB] 4DW path");
    push_raw(64'h60000002_010000FF, 1'b1, 1'b0, 8'h00);
    push_raw(64'h00000001_00001000, 1'b0, 1'b0, 8'h00);
    push_raw(64'hEFCDAB89_67452301, 1'b0, 1'b1, 8'h00);
    apply_stimulus(64'h0000_0001_0000_1000, 64'h0123_4567_89AB_CDEF);
    wait_ack(0, lat);
    check_output("latency_4dw", lat, 5);

    $display("[TB] back-to-back, grant dropped mid-TLP");
    cfg_completer_id = 16'hA5C3;
    push_tlp(64'h0000_0000_8000_0007, 64'hCAFE_F00D_1357_9BDF, 3);
    apply_stimulus(64'h0000_0000_8000_0007, 64'hCAFE_F00D_1357_9BDF);
    wait_ack(2, lat);
    check_output("latency_b2b", lat, 5);

    $display("[TB] backpressure");
    stall_en = 1'b1;
    push_tlp(64'h0000_0000_0000_0040, 64'h1111_2222_3333_4444, 3);
    apply_stimulus(64'h0000_0000_0000_0040, 64'h1111_2222_3333_4444);
    wait_ack(0, lat);
    check_output("latency_stall", lat, 14);
    stall_en = 1'b0;

    $display("[TB] arbitration");
    tx_grant = 1'b0;
    push_tlp(64'h0000_00AB_0000_0100, 64'h5555_6666_7777_8888, 3);
    apply_stimulus(64'h0000_00AB_0000_0100, 64'h5555_6666_7777_8888);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("arb_req_no_grant", tx_req, 1);
      check_output("arb_sof_no_grant", trn_tsof_n, 1);
    end
    tx_grant = 1'b1; trn_tbuf_av = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("arb_req_no_buf", tx_req, 1);
      check_output("arb_sof_no_buf", trn_tsof_n, 1);
    end
    trn_tbuf_av = 1'b1;
    wait_ack(0, lat);

    $display("[TB] link loss in BEAT1");
    push_tlp(64'h0000_0000_0BAD_F00C, 64'h0F0E_0D0C_0B0A_0908, 1);
    push_tlp(64'h0000_0000_0BAD_F00C, 64'h0F0E_0D0C_0B0A_0908, 3);
    apply_stimulus(64'h0000_0000_0BAD_F00C, 64'h0F0E_0D0C_0B0A_0908);
    repeat (3) begin @(posedge clk); #1; end
    check_output("ll_beat1_src_rdy_n", trn_tsrc_rdy_n, 0);
    trn_lnk_up_n = 1'b1;
    @(posedge clk); #1;
    check_output("ll_tx_done", tx_done, 1);
    check_output("ll_no_ack", gc_updt_ack, 0);
    check_output("ll_src_rdy_n", trn_tsrc_rdy_n, 1);
    check_output("ll_eof_n", trn_teof_n, 1);
    check_output("ll_tx_req", tx_req, 0);
    repeat (3) begin @(posedge clk); #1; end
    check_output("ll_idle_tx_req", tx_req, 0);
    check_output("ll_cnt_held", gc_wr_cnt, 5);
    trn_lnk_up_n = 1'b0;
    wait_ack(0, lat);

    $display("[TB] reset in BEAT1");
    push_tlp(64'h0000_0000_0000_1230, 64'h0102_0304_0506_0708, 1);
    apply_stimulus(64'h0000_0000_0000_1230, 64'h0102_0304_0506_0708);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_output("rr_tx_req", tx_req, 0);
    check_output("rr_src_rdy_n", trn_tsrc_rdy_n, 1);
    check_output("rr_sof_n", trn_tsof_n, 1);
    check_output("rr_eof_n", trn_teof_n, 1);
    check_output("rr_td", trn_td, 0);
    check_output("rr_trem_n", trn_trem_n, 8'hFF);
    check_output("rr_cnt", gc_wr_cnt, 0);
    gc_updt = 1'b0;
    exp_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_tlp(64'h0000_0000_0000_1230, 64'h0102_0304_0506_0708, 3);
    apply_stimulus(64'h0000_0000_0000_1230, 64'h0102_0304_0506_0708);
    wait_ack(0, lat);
    check_output("latency_after_rst", lat, 5);

    repeat (3) @(posedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
